// File: rtl/load_types_pkg.sv
// Shared load-unit types and helpers: RV32 load funct3 encodings, controller states,
// access size and word-boundary crossing.
package load_types_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } load_funct3_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD0  = 2'd1,
    ST_RD1  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  // Access size in bytes; 0 marks an illegal funct3.
  function automatic logic [2:0] load_size(input logic [2:0] funct3);
    case (funct3)
      3'd0, 3'd4: load_size = 3'd1;
      3'd1, 3'd5: load_size = 3'd2;
      3'd2:       load_size = 3'd4;
      default:    load_size = 3'd0;
    endcase
  endfunction

  function automatic logic load_crosses(input logic [2:0] funct3, input logic [1:0] off);
    load_crosses = (({1'b0, load_size(funct3)} + {2'b00, off}) > 4'd4);
  endfunction

endpackage

// File: rtl/load_lane_merge.sv
// Combinational lane shift/merge of up to two cache words, followed by
// sign/zero extension according to the load funct3.
module load_lane_merge
  import load_types_pkg::*;
(
  input  logic [31:0] i_w0,
  input  logic [31:0] i_w1,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_w1_masked;
  logic [5:0]  w_shift;
  logic [31:0] w_raw;

  assign w_w1_masked = load_crosses(i_funct3, i_off) ? i_w1 : 32'h0000_0000;
  assign w_shift     = {1'b0, i_off, 3'b000};
  // Shifting the 64-bit {w1,w0} right by 8*off equals (w0 >> 8*off) | (w1 << 8*(4-off)).
  assign w_raw       = 32'({w_w1_masked, i_w0} >> w_shift);

  // Extension by load type
  always_comb begin
    o_data = 32'h0000_0000;
    case (i_funct3)
      LB:      o_data = {{24{w_raw[7]}}, w_raw[7:0]};
      LBU:     o_data = {24'h00_0000, w_raw[7:0]};
      LH:      o_data = {{16{w_raw[15]}}, w_raw[15:0]};
      LHU:     o_data = {16'h0000, w_raw[15:0]};
      LW:      o_data = w_raw;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_align_ctrl.sv
// Load sequencer: accepts a byte-addressed load, issues one or two word reads
// to the cache and returns the merged, extended result as a one-cycle response.
module load_align_ctrl
  import load_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_read,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_nx;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic [31:0] r_w0;
  logic [31:0] r_w1;
  logic        w_illegal;
  logic        w_cross;
  logic [31:0] w_word_addr;
  logic [31:0] w_merged;

  assign w_illegal   = (load_size(req_funct3) == 3'd0);
  assign w_cross     = load_crosses(r_funct3, r_addr[1:0]);
  assign w_word_addr = {r_addr[31:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Request latch and captured cache words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= 32'h0000_0000;
      r_funct3 <= 3'd0;
      r_err    <= 1'b0;
      r_w0     <= 32'h0000_0000;
      r_w1     <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_funct3 <= req_funct3;
            r_err    <= w_illegal;
            r_w0     <= 32'h0000_0000;
            r_w1     <= 32'h0000_0000;
          end
        end
        ST_RD0: begin
          if (mem_resp) r_w0 <= mem_rdata;
        end
        ST_RD1: begin
          if (mem_resp) r_w1 <= mem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode from registered state only
  always_comb begin
    w_state_nx  = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_read    = 1'b0;
    mem_address = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nx = w_illegal ? ST_DONE : ST_RD0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_RD0: begin
        mem_read    = 1'b1;
        mem_address = w_word_addr;
        if (mem_resp) begin
          w_state_nx = w_cross ? ST_RD1 : ST_DONE;
        end else begin
          w_state_nx = ST_RD0;
        end
      end
      ST_RD1: begin
        mem_read    = 1'b1;
        mem_address = w_word_addr + 32'd4;
        if (mem_resp) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_RD1;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  load_lane_merge u_merge (
    .i_w0     (r_w0),
    .i_w1     (r_w1),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_merged)
  );

  assign resp_data = ((r_state == ST_DONE) && !r_err) ? w_merged : 32'h0000_0000;
  assign resp_err  = (r_state == ST_DONE) && r_err;

endmodule
